// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// default sizing, the FSM state type and the BCD nibble type.
package bin2bcd_pkg;

    localparam int IN_W_DEF   = 9;
    localparam int DIGITS_DEF = 3;
    localparam int BCD_W      = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef logic [BCD_W-1:0] nibble_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  nibble_t i_nib,
    output nibble_t o_nib
);

    // Conditional add-3 on a single 4-bit digit (wraps within 4 bits).
    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) begin
            o_nib = i_nib + 4'd3;
        end else begin
            o_nib = i_nib;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a start/busy/done handshake. Optional leading-zero blank flags are
// enabled with the macro BIN2BCD_BLANK_EN; without it, blank stays zero.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_F = BCD_W * DIGITS;
    localparam int SH_W  = BCD_F + IN_W;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    state_t             r_state;
    state_t             w_state_nx;
    logic [SH_W-1:0]    r_shift;
    logic [SH_W-1:0]    w_shift_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               r_busy;
    logic               w_busy_nx;
    logic               r_done;
    logic               w_done_nx;
    logic [BCD_F-1:0]   r_bcd;
    logic [BCD_F-1:0]   w_bcd_nx;
    logic [DIGITS-1:0]  r_blank;
    logic [DIGITS-1:0]  w_blank_nx;

    logic [BCD_F-1:0]   w_corr_field;
    logic [SH_W-1:0]    w_corrected;
    logic [SH_W-1:0]    w_shifted;
    logic [DIGITS-1:0]  w_blank_calc;

    // One add-3 cell per BCD digit, operating on the current register contents.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_shift[IN_W + g*BCD_W +: BCD_W]),
            .o_nib (w_corr_field[g*BCD_W +: BCD_W])
        );
    end

    assign w_corrected = {w_corr_field, r_shift[IN_W-1:0]};
    assign w_shifted   = w_corrected << 1;

`ifdef BIN2BCD_BLANK_EN
    // Blank a digit only when it and every higher digit are zero; ones never blanks.
    always_comb begin
        logic all_zero;
        all_zero     = 1'b1;
        w_blank_calc = {DIGITS{1'b0}};
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (w_shifted[IN_W + i*BCD_W +: BCD_W] == 4'd0) begin
                all_zero = all_zero;
            end else begin
                all_zero = 1'b0;
            end
            w_blank_calc[i] = all_zero;
        end
    end
`else
    assign w_blank_calc = {DIGITS{1'b0}};
`endif

    // Next-state and next-output logic for the IDLE/SHIFT controller.
    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_cnt_nx   = r_cnt;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_bcd_nx   = r_bcd;
        w_blank_nx = r_blank;
        case (r_state)
            IDLE: begin
                w_busy_nx = 1'b0;
                if (start) begin
                    w_shift_nx = {{BCD_F{1'b0}}, bin_in};
                    w_cnt_nx   = {CNT_W{1'b0}};
                    w_busy_nx  = 1'b1;
                    w_state_nx = SHIFT;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            SHIFT: begin
                w_shift_nx = w_shifted;
                w_cnt_nx   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                // The shift taken while cnt == IN_W-1 is the last of IN_W shifts.
                if (r_cnt == CNT_W'(IN_W - 1)) begin
                    w_state_nx = IDLE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_bcd_nx   = w_shifted[SH_W-1:IN_W];
                    w_blank_nx = w_blank_calc;
                end else begin
                    w_state_nx = SHIFT;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= {SH_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= {BCD_F{1'b0}};
            r_blank <= {DIGITS{1'b0}};
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_bcd   <= w_bcd_nx;
            r_blank <= w_blank_nx;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;
    assign blank   = r_blank;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vectors push expected results
// into a scoreboard queue; a monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic [2:0]  blank;

    int n_checks = 0;
    int n_errors = 0;

`ifdef BIN2BCD_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic [14:0] exp_q[$];

    bin2bcd_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .blank   (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] mk_exp(input logic [11:0] b, input logic [2:0] bl);
        return {(BLANK_ON ? bl : 3'b000), b};
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got bcd %0h expected no done", bcd_out);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                check("bcd_out", {20'd0, bcd_out}, {20'd0, e[11:0]});
                check("blank", {29'd0, blank}, {29'd0, e[14:12]});
            end
        end
    end

    // Wait (bounded) for done; k counts negedges after the accepting edge.
    task automatic wait_done(output int k, output int busy_n, output bit found);
        k = 0; busy_n = 0; found = 1'b0;
        while (k < 30 && !found) begin
            if (done === 1'b1) found = 1'b1;
            else begin
                if (busy === 1'b1) busy_n++;
                @(negedge clk);
                k++;
            end
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(input logic [8:0] v, input logic [11:0] b, input logic [2:0] bl);
        int k, bn;
        bit f;
        @(negedge clk);
        bin_in = v; start = 1'b1;
        exp_q.push_back(mk_exp(b, bl));
        @(negedge clk);
        start = 1'b0;
        wait_done(k, bn, f);
        if (f) begin
            check("latency", k, 9);
            check("busy_cycles", bn, 9);
            @(negedge clk);
            check("done_one_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int k, bn;
        bit f;
        rst = 1'b1; start = 1'b0; bin_in = 9'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {20'd0, bcd_out}, 32'd0);
        check("rst_blank", {29'd0, blank}, 32'd0);

        run_one(9'd0,   12'h000, 3'b110);
        run_one(9'd255, 12'h255, 3'b000);
        run_one(9'd510, 12'h510, 3'b000);
        run_one(9'd9,   12'h009, 3'b110);

        // Start 123, then a stray start with 77 at cycle 4 must be ignored.
        @(negedge clk);
        bin_in = 9'd123; start = 1'b1;
        exp_q.push_back(mk_exp(12'h123, 3'b000));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        bin_in = 9'd77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("ignored_start_busy", {31'd0, busy}, 32'd0);

        // Start 200 and reset mid-conversion: no done, outputs cleared.
        @(negedge clk);
        bin_in = 9'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bcd", {20'd0, bcd_out}, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_no_busy", {31'd0, busy}, 32'd0);
        run_one(9'd42, 12'h042, 3'b100);

        // Back-to-back: start held through the done cycle re-arms with 101.
        @(negedge clk);
        bin_in = 9'd100; start = 1'b1;
        exp_q.push_back(mk_exp(12'h100, 3'b000));
        exp_q.push_back(mk_exp(12'h101, 3'b000));
        @(negedge clk);
        bin_in = 9'd101;
        wait_done(k, bn, f);
        check("b2b_first_latency", k, 9);
        @(negedge clk);
        start = 1'b0;
        check("b2b_rearm_busy", {31'd0, busy}, 32'd1);
        // Accepted on the edge closing the done cycle, so the next done is IN_W cycles on.
        wait_done(k, bn, f);
        check("b2b_second_latency", k, 9);
        check("b2b_busy_cycles", bn, 9);
        repeat (3) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
